// File: rtl/bkram_sd_ctrl_pkg.sv
// Shared types and constants for the backup-RAM SD save/load sequencer.
// Sector geometry is fixed by the hps_io block-transfer port.
package bk_pkg;
   localparam int SECTOR_BYTES = 512;
   localparam int SECT_BITS    = $clog2(SECTOR_BYTES);

   typedef enum logic [1:0] {BK_IDLE, BK_REQ, BK_XFER} bk_state_e;
endpackage

// File: rtl/bkram_sd_ctrl_if.sv
// SD block-transfer handshake between the sequencer (master) and hps_io (slave).
interface bkram_sd_ctrl_if;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;

   modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
   modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/bkram_sd_ctrl_watchdog.sv
// Per-sector transfer watchdog: reloadable up-counter that flags expiry
// on the TIMEOUT-th running cycle.
module bk_watchdog #(
   parameter int unsigned TIMEOUT = 10_000_000
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic load_i,
   input  logic run_i,
   output logic expired_o
);
   localparam int W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign expired_o = run_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = '0;
      else if (run_i && !expired_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/bkram_sd_ctrl.sv
// Backup-RAM save/load sequencer: moves NVRAM sectors over the hps_io SD port,
// tracks dirty state and aborts a transfer when sd_ack stalls.
module bkram_sd_ctrl
   import bk_pkg::*;
#(
   parameter int          SECT_W   = 6,
   parameter int unsigned TIMEOUT  = 24'd10_000_000,
   parameter bit          AUTOSAVE = 1'b1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        downloading,
   input  logic        img_mounted,
   input  logic        img_readonly,
   input  logic [63:0] img_size,
   input  logic        load_req,
   input  logic        save_req,
   input  logic        osd_status,
   input  logic        nv_we,
   bkram_sd_ctrl_if.master sd,
   output logic        bk_ena,
   output logic        bk_loading,
   output logic        bk_busy,
   output logic        dirty,
   output logic        err
);
   bk_state_e         state_q, state_d;
   logic [SECT_W-1:0] lba_q, lba_d, last_q, last_d;
   logic              save_q, save_d;
   logic              rd_q, rd_d, wr_q, wr_d;
   logic              dirty_q, dirty_d, err_q, err_d, ena_q, ena_d;
   logic              old_ack_q, old_dl_q, old_load_q, old_save_q, old_osd_q;

   logic              ack_rise, ack_fall, dl_rise, dl_fall, load_rise, save_rise, osd_rise;
   logic              start_load, start_save, wd_load, wd_expired;
   logic [SECT_W:0]   n_load;
   logic [SECT_W-1:0] last_load;
   logic              round_up;

   assign ack_rise  = ~old_ack_q & sd.sd_ack;
   assign ack_fall  = old_ack_q & ~sd.sd_ack;
   assign dl_rise   = downloading & ~old_dl_q;
   assign dl_fall   = ~downloading & old_dl_q;
   assign load_rise = load_req & ~old_load_q;
   assign save_rise = save_req & ~old_save_q;
   assign osd_rise  = osd_status & ~old_osd_q;

   // Sector count rounds a partial tail sector up and saturates at the full NVRAM.
   assign round_up = |img_size[SECT_BITS-1:0];
   always_comb begin
      if (|img_size[63:SECT_BITS+SECT_W])
         n_load = {1'b1, {SECT_W{1'b0}}};
      else
         n_load = {1'b0, img_size[SECT_BITS+SECT_W-1:SECT_BITS]} + {{SECT_W{1'b0}}, round_up};
   end
   // n_load == 0 wraps to all ones, which is exactly the whole-NVRAM manual load.
   assign last_load = SECT_W'(n_load - 1'b1);

   assign start_load = ena_q & ((dl_fall & (n_load != '0)) | load_rise);
   assign start_save = ena_q & ~start_load & (save_rise | (osd_rise & dirty_q & AUTOSAVE));

   assign bk_busy    = (state_q != BK_IDLE);
   assign bk_loading = bk_busy & ~save_q;
   assign bk_ena     = ena_q;
   assign dirty      = dirty_q;
   assign err        = err_q;
   assign sd.sd_lba  = 32'(lba_q);
   assign sd.sd_rd   = rd_q;
   assign sd.sd_wr   = wr_q;

   always_comb begin
      state_d = state_q;
      lba_d   = lba_q;
      last_d  = last_q;
      save_d  = save_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      err_d   = err_q;
      wd_load = 1'b0;
      ena_d   = ena_q;
      dirty_d = dirty_q;

      if (dl_rise)
         ena_d = 1'b0;
      if (downloading & img_mounted & ~img_readonly)
         ena_d = 1'b1;

      if (nv_we && !bk_loading)
         dirty_d = 1'b1;

      case (state_q)
         BK_IDLE: begin
            if (start_load || start_save) begin
               state_d = BK_REQ;
               lba_d   = '0;
               save_d  = start_save;
               last_d  = start_save ? {SECT_W{1'b1}} : last_load;
               err_d   = 1'b0;
               rd_d    = start_load;
               wr_d    = start_save;
               wd_load = 1'b1;
               if (start_save)
                  dirty_d = 1'b0;
            end
         end
         BK_REQ: begin
            if (ack_rise) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = BK_XFER;
            end
         end
         BK_XFER: begin
            if (ack_fall) begin
               if (lba_q == last_q) begin
                  state_d = BK_IDLE;
                  if (!save_q)
                     dirty_d = 1'b0;
               end else begin
                  lba_d   = lba_q + 1'b1;
                  state_d = BK_REQ;
                  rd_d    = ~save_q;
                  wr_d    = save_q;
                  wd_load = 1'b1;
               end
            end
         end
         default: state_d = BK_IDLE;
      endcase

      // A stalled sector aborts the whole transfer; an unfinished save leaves data unsaved.
      if (wd_expired) begin
         state_d = BK_IDLE;
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         err_d   = 1'b1;
         if (save_q)
            dirty_d = 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= BK_IDLE;
         lba_q      <= '0;
         last_q     <= '0;
         save_q     <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         dirty_q    <= 1'b0;
         err_q      <= 1'b0;
         ena_q      <= 1'b0;
         old_ack_q  <= sd.sd_ack;
         old_dl_q   <= downloading;
         old_load_q <= load_req;
         old_save_q <= save_req;
         old_osd_q  <= osd_status;
      end else begin
         state_q    <= state_d;
         lba_q      <= lba_d;
         last_q     <= last_d;
         save_q     <= save_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         dirty_q    <= dirty_d;
         err_q      <= err_d;
         ena_q      <= ena_d;
         old_ack_q  <= sd.sd_ack;
         old_dl_q   <= downloading;
         old_load_q <= load_req;
         old_save_q <= save_req;
         old_osd_q  <= osd_status;
      end
   end

   bk_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .load_i    (wd_load),
      .run_i     (bk_busy),
      .expired_o (wd_expired)
   );
endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Directed bench for bkram_sd_ctrl: auto/manual load, save, autosave,
// watchdog abort, trigger priority, reset mid-transfer and mount gating.
module tb_bkram_sd_ctrl;
   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        downloading = 1'b0;
   logic        img_mounted = 1'b0;
   logic        img_readonly = 1'b0;
   logic [63:0] img_size = '0;
   logic        load_req = 1'b0;
   logic        save_req = 1'b0;
   logic        osd_status = 1'b0;
   logic        nv_we = 1'b0;
   logic        bk_ena, bk_loading, bk_busy, dirty, err;

   int n_assert = 0;
   int n_fail = 0;

   bkram_sd_ctrl_if sd_if ();

   bkram_sd_ctrl #(.SECT_W(6), .TIMEOUT(100), .AUTOSAVE(1'b1)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .downloading  (downloading),
      .img_mounted  (img_mounted),
      .img_readonly (img_readonly),
      .img_size     (img_size),
      .load_req     (load_req),
      .save_req     (save_req),
      .osd_status   (osd_status),
      .nv_we        (nv_we),
      .sd           (sd_if),
      .bk_ena       (bk_ena),
      .bk_loading   (bk_loading),
      .bk_busy      (bk_busy),
      .dirty        (dirty),
      .err          (err)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!(sd_if.sd_rd || sd_if.sd_wr) && n < 60) begin
         tick();
         n++;
      end
      chk("req_seen", 64'(sd_if.sd_rd | sd_if.sd_wr), 64'd1);
   endtask

   // Plays hps_io for one sector: checks the request, acks for 'hold' cycles.
   task automatic serve(input bit is_wr, input int lba, input int hold, input bit we);
      wait_req();
      chk("req_rd", 64'(sd_if.sd_rd), 64'(!is_wr));
      chk("req_wr", 64'(sd_if.sd_wr), 64'(is_wr));
      chk("req_lba", 64'(sd_if.sd_lba), 64'(lba));
      repeat (3) tick();
      sd_if.sd_ack = 1'b1;
      tick();
      chk("req_drop", 64'(sd_if.sd_rd | sd_if.sd_wr), 64'd0);
      chk("loading_in_ack", 64'(bk_loading), 64'(!is_wr));
      if (we) nv_we = 1'b1;
      repeat (hold - 1) begin
         tick();
         nv_we = 1'b0;
      end
      chk("lba_stable", 64'(sd_if.sd_lba), 64'(lba));
      sd_if.sd_ack = 1'b0;
      tick();
   endtask

   initial begin
      sd_if.sd_ack = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_rd", 64'(sd_if.sd_rd), 64'd0);
      chk("rst_wr", 64'(sd_if.sd_wr), 64'd0);
      chk("rst_lba", 64'(sd_if.sd_lba), 64'd0);
      chk("rst_ena", 64'(bk_ena), 64'd0);
      chk("rst_busy", 64'(bk_busy), 64'd0);
      chk("rst_dirty", 64'(dirty), 64'd0);
      chk("rst_err", 64'(err), 64'd0);

      // Read-only mount: no bk_ena, every trigger ignored
      downloading = 1'b1; tick();
      img_mounted = 1'b1; img_readonly = 1'b1; img_size = 64'd1536; tick();
      img_mounted = 1'b0; tick();
      chk("ro_ena", 64'(bk_ena), 64'd0);
      downloading = 1'b0; tick(); tick();
      chk("ro_autoload", 64'(bk_busy), 64'd0);
      load_req = 1'b1; tick(); tick();
      chk("ro_load", 64'(sd_if.sd_rd), 64'd0);
      load_req = 1'b0; save_req = 1'b1; tick(); tick();
      chk("ro_save", 64'(sd_if.sd_wr), 64'd0);
      save_req = 1'b0; tick();

      // Writable mount then auto-load of 3 sectors
      nv_we = 1'b1; tick(); nv_we = 1'b0;
      chk("pre_dirty", 64'(dirty), 64'd1);
      downloading = 1'b1; tick();
      img_mounted = 1'b1; img_readonly = 1'b0; img_size = 64'd1536; tick();
      img_mounted = 1'b0; tick();
      chk("rw_ena", 64'(bk_ena), 64'd1);
      downloading = 1'b0; tick();
      chk("al_rd", 64'(sd_if.sd_rd), 64'd1);
      chk("al_loading", 64'(bk_loading), 64'd1);
      for (int i = 0; i < 3; i++) serve(1'b0, i, 40, 1'b0);
      tick();
      chk("al_busy_end", 64'(bk_busy), 64'd0);
      chk("al_loading_end", 64'(bk_loading), 64'd0);
      chk("al_dirty_end", 64'(dirty), 64'd0);

      // Manual load of a 513-byte image rounds up to 2 sectors
      img_size = 64'd513; load_req = 1'b1; tick();
      for (int i = 0; i < 2; i++) serve(1'b0, i, 4, 1'b0);
      tick();
      chk("ml513_done", 64'(bk_busy), 64'd0);
      load_req = 1'b0; tick();

      // Oversized image saturates to 64 sectors
      img_size = 64'd1 << 40; load_req = 1'b1; tick();
      for (int i = 0; i < 64; i++) serve(1'b0, i, 4, 1'b0);
      tick();
      chk("mlbig_done", 64'(bk_busy), 64'd0);
      load_req = 1'b0; tick();

      // Zero-size image: manual load covers the whole NVRAM
      img_size = 64'd0; load_req = 1'b1; tick();
      for (int i = 0; i < 64; i++) serve(1'b0, i, 4, 1'b0);
      tick();
      chk("ml0_done", 64'(bk_busy), 64'd0);
      load_req = 1'b0; tick();

      // Save: simultaneous write loses to save start, write at sector 10 re-dirties
      nv_we = 1'b1; tick(); nv_we = 1'b0;
      chk("sv_dirty_pre", 64'(dirty), 64'd1);
      nv_we = 1'b1; save_req = 1'b1; tick(); nv_we = 1'b0;
      chk("sv_dirty_start", 64'(dirty), 64'd0);
      chk("sv_wr_start", 64'(sd_if.sd_wr), 64'd1);
      for (int i = 0; i < 64; i++) serve(1'b1, i, 4, (i == 10));
      tick();
      chk("sv_busy_end", 64'(bk_busy), 64'd0);
      chk("sv_dirty_end", 64'(dirty), 64'd1);
      chk("sv_err_end", 64'(err), 64'd0);
      save_req = 1'b0; tick();

      // Load and save together: load only; save edge while busy is dropped
      img_size = 64'd1536; load_req = 1'b1; save_req = 1'b1; tick();
      chk("sim_rd", 64'(sd_if.sd_rd), 64'd1);
      chk("sim_wr", 64'(sd_if.sd_wr), 64'd0);
      save_req = 1'b0; tick();
      save_req = 1'b1; tick();
      for (int i = 0; i < 3; i++) serve(1'b0, i, 4, 1'b0);
      tick();
      chk("sim_busy_end", 64'(bk_busy), 64'd0);
      chk("sim_dirty_end", 64'(dirty), 64'd0);
      tick();
      chk("sim_no_queue", 64'(sd_if.sd_wr), 64'd0);
      load_req = 1'b0; save_req = 1'b0; tick();

      // Autosave on OSD open with no ack: watchdog abort at cycle 101
      nv_we = 1'b1; tick(); nv_we = 1'b0;
      osd_status = 1'b1; tick();
      chk("as_wr", 64'(sd_if.sd_wr), 64'd1);
      chk("as_dirty_clr", 64'(dirty), 64'd0);
      repeat (99) tick();
      chk("wd_err_100", 64'(err), 64'd0);
      chk("wd_wr_100", 64'(sd_if.sd_wr), 64'd1);
      tick();
      chk("wd_err_101", 64'(err), 64'd1);
      chk("wd_wr_101", 64'(sd_if.sd_wr), 64'd0);
      chk("wd_busy_101", 64'(bk_busy), 64'd0);
      chk("wd_dirty_101", 64'(dirty), 64'd1);
      osd_status = 1'b0; tick();

      // Reset during sector 5 of a save
      save_req = 1'b1; tick();
      chk("rs_err_clr", 64'(err), 64'd0);
      for (int i = 0; i < 5; i++) serve(1'b1, i, 4, 1'b0);
      wait_req();
      chk("rs_lba5", 64'(sd_if.sd_lba), 64'd5);
      reset = 1'b1; tick();
      chk("rs_wr", 64'(sd_if.sd_wr), 64'd0);
      chk("rs_lba", 64'(sd_if.sd_lba), 64'd0);
      chk("rs_busy", 64'(bk_busy), 64'd0);
      chk("rs_err", 64'(err), 64'd0);
      chk("rs_ena", 64'(bk_ena), 64'd0);
      reset = 1'b0; save_req = 1'b0; tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/bkram_sd_ctrl.md
# bkram_sd_ctrl

Backup-RAM save/load sequencer between the hps_io SD block-transfer port and the core's dual-port NVRAM. It serves any NVRAM size, as a power-of-two count of 512-byte sectors. It loads partial images sized from `img_size`, tracks dirty state from core writes, and can autosave when the OSD opens. It guards every sector transfer with an `sd_ack` watchdog. It sits in `emu` beside the NVRAM `dpram` and replaces ad-hoc per-core save logic.

## Interface
Parameters:
- `SECT_W`, default 6: log2 of the sector count (64 sectors = 32 KiB).
- `TIMEOUT`, default 24'd10_000_000: `clk_sys` cycles allowed per sector before abort.
- `AUTOSAVE`, default 1: enables the autosave on OSD open.

Ports:
- `clk_sys` in 1: system clock. Single clock domain.
- `reset` in 1: reset is synchronous and active-high.
- `downloading` in 1: ROM download in progress.
- `img_mounted` in 1: pulse from hps_io.
- `img_readonly` in 1: mounted image is read-only.
- `img_size` in 64: mounted image size in bytes.
- `load_req` in 1: level from OSD status; acted on at the rising edge.
- `save_req` in 1: level from OSD status; acted on at the rising edge.
- `osd_status` in 1: OSD open.
- `nv_we` in 1: core NVRAM write strobe.
- `sd_ack` in 1: hps_io transfer acknowledge.
- `sd_lba` out 32: sector address; bits above `SECT_W` are always 0.
- `sd_rd` out 1: sector read request.
- `sd_wr` out 1: sector write request.
- `bk_ena` out 1: a writable save file is mounted.
- `bk_loading` out 1: load in progress; the parent ORs this into the core reset.
- `bk_busy` out 1: any transfer in progress.
- `dirty` out 1: NVRAM modified since the last load or save.
- `err` out 1: last transfer timed out; sticky.

## Operation
- **Reset values:** all outputs are 0.
  - Reset mid-transfer returns to IDLE at once, with `sd_rd`/`sd_wr` deasserted on the next edge.
  - `err` and `dirty` are cleared.
- **bk_ena:**
  - Cleared on the rising edge of `downloading`.
  - Set when `downloading & img_mounted & ~img_readonly`.
- **Sector count for a load:** `n_load = min(2^SECT_W, ceil(img_size/512))`.
  - Compute on bits [63:9] plus an OR-reduce of [8:0].
  - Any upper bits beyond `SECT_W+9` set saturate to `2^SECT_W`.
  - `n_load == 0` starts no load.
- **Triggers, evaluated only in IDLE with `bk_ena = 1`:**
  - Auto-load: falling edge of `downloading` with `n_load > 0`.
  - Manual load: rising edge of `load_req`. Loads `n_load` sectors, or all `2^SECT_W` sectors if `n_load == 0`.
  - Manual save: rising edge of `save_req`.
  - Autosave: rising edge of `osd_status` while `dirty & AUTOSAVE`.
  - Priority: auto-load > load > save > autosave.
  - Edges arriving while busy are discarded, not queued.
- **States:**
  - IDLE: on a trigger, set `sd_lba = 0`, latch the direction and the last sector, clear `err`, go to REQ. A save also clears `dirty`.
  - REQ: `sd_rd` (load) or `sd_wr` (save) is held at 1. On the `sd_ack` rising edge, drop the request and go to XFER.
  - XFER: wait for the `sd_ack` falling edge.
    - If `sd_lba` equals the last sector, go to IDLE.
    - Otherwise increment `sd_lba` and go to REQ.
- **Watchdog:**
  - The counter restarts on entry to REQ.
  - At `TIMEOUT` in REQ or XFER, set `err = 1`, drop both requests, go to IDLE.
  - An aborted save sets `dirty = 1` again.
- **dirty:**
  - Set by `nv_we` when not loading. Writes during a save re-set it.
  - Cleared at the start of a save and at the completion of a load.
- **Flags:** `bk_busy = (state != IDLE)`. `bk_loading` = busy and direction is load.

## Timing
- `sd_ack` is registered once (`old_ack`). Edges are detected as `~old_ack & sd_ack` and `old_ack & ~sd_ack`.
- Request latency:
  - The trigger edge is seen at cycle t.
  - IDLE→REQ and `sd_rd`/`sd_wr` are high at t+1.
  - The request drops at the edge after the ack rising edge is detected.
- `sd_lba` changes only on the XFER→REQ edge, and is stable throughout the ack-high window (the `dpram` port-b address uses it).
- The next request asserts 1 cycle after the `sd_ack` fall is detected.
- An `nv_we` in the same cycle as save start: the save start wins and `dirty` ends 0. The write lands in the sector data but does not re-set `dirty`.

## Structure
- Package `bk_pkg`:
  - `typedef enum logic [1:0] {BK_IDLE, BK_REQ, BK_XFER}`.
  - `localparam SECTOR_BYTES = 512`.
  - `SECT_BITS = 9`.
- One sub-module, `bk_watchdog`: a loadable counter with an expiry pulse, width `$clog2(TIMEOUT+1)`.

## Test plan
- **Auto-load:** `bk_ena = 1`, `img_size = 1536`, `downloading` falls → 3 read requests at lba 0, 1, 2, each with a 40-cycle ack → `bk_loading` high throughout, then 0; `dirty = 0`.
- **Manual save with SECT_W = 6:**
  - `nv_we` pulse → `dirty = 1`.
  - `save_req` edge → 64 `sd_wr` requests, lba 0..63; `dirty = 0`.
  - `nv_we` during sector 10 → `dirty = 1` at the end.
- **Watchdog:** `TIMEOUT = 100`, `sd_ack` never rises → at cycle 101 `err = 1`, `sd_wr = 0`, state IDLE, `dirty` restored to 1.
- **Simultaneous triggers:** `load_req` and `save_req` rise in the same cycle → a load only. A second `save_req` edge while busy is ignored.
- **Reset mid-transfer:** `reset` pulse at sector 5 of a save → next cycle `sd_wr = 0`, `sd_lba = 0`, `bk_busy = 0`, `err = 0`.
- **Gating:**
  - `img_size = 2^40` → `n_load = 64`.
  - `img_readonly = 1` at mount → `bk_ena = 0`, and all triggers are ignored.
